// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback arbiter slice.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // Width of a pointer able to index n requesters (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake and register-file write-port bundle for regfile_write_arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteRegister;
  logic [DATA_W-1:0]         WriteData;
  logic                      busy;
  logic                      contention;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, RegWrite, WriteRegister, WriteData, busy, contention
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, RegWrite, WriteRegister, WriteData, busy, contention
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first valid at or after ptr_i, wrapping.
// With ptr_i tied to zero it degenerates to lowest-index-wins.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [PTR_W-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single registered register-file write port.
// Define REGFILE_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  regfile_write_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = ptr_w(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               take;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               multi_valid;

  logic               regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               cont_q, cont_d;

`ifdef REGFILE_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take)
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign take        = grant_any & ~stall & ~reset;
  assign sel_addr    = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data    = bus.req_data[grant_idx*DATA_W +: DATA_W];
  assign multi_valid = |(bus.req_valid & (bus.req_valid - 1'b1));

  always_comb begin
    regwrite_d = take && (sel_addr != ADDR_W'(REG_ZERO));
    wreg_d     = take ? sel_addr : wreg_q;
    wdata_d    = take ? sel_data : wdata_q;
    cont_d     = stall ? cont_q : multi_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      cont_q     <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      cont_q     <= cont_d;
    end
  end

  assign bus.req_ready     = take ? grant : '0;
  // Masking with reset keeps a write already registered from reaching the register file.
  assign bus.RegWrite      = regwrite_q & ~reset;
  assign bus.WriteRegister = wreg_q;
  assign bus.WriteData     = wdata_q;
  assign bus.busy          = |bus.req_valid;
  assign bus.contention    = cont_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_held: assert property (@(posedge clk) disable iff (reset)
      (bus.req_valid[i] && !bus.req_ready[i]) |=> bus.req_valid[i]);
  end

endmodule
